// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and the Q8.8 output saturation helper for the FC engine.
package fc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FRAC_W   = 8;
  localparam int unsigned ACC_W    = 40;
  localparam int unsigned MAX_CIN  = 1024;
  localparam int unsigned MAX_COUT = 1024;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned IDX_W    = 10;

  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {
    StIdle,
    StLoadIf,
    StMac,
    StFlush,
    StBias,
    StOut,
    StDone
  } fc_state_e;

  // Drop the fraction (floor) and clamp into the signed 16-bit range.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_W;
    if (sh > ACC_SAT_MAX) begin
      return 16'h7FFF;
    end else if (sh < ACC_SAT_MIN) begin
      return 16'h8000;
    end
    return sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Registered 16x16 multiplier feeding a wide accumulator; strobes the completed dot product
// on the product that carries the last input-channel index.
module fc_mac
  import fc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_feat,
  input  logic signed [DATA_W-1:0] i_wgt,
  output logic                     o_wb,
  output logic signed [ACC_W-1:0]  o_wb_data
);

  logic signed [2*DATA_W-1:0] r_prod;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       r_pvld;
  logic                       r_plast;

  assign w_prod = (2*DATA_W)'(i_feat) * (2*DATA_W)'(i_wgt);
  assign w_sum  = r_acc + ACC_W'(r_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod  <= '0;
      r_pvld  <= 1'b0;
      r_plast <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_pvld  <= i_valid;
      r_plast <= i_valid & i_last;
      if (i_valid) begin
        r_prod <= w_prod;
      end
      if (i_clr) begin
        r_acc <= '0;
      end else if (r_pvld) begin
        r_acc <= r_plast ? '0 : w_sum;
      end
    end
  end

  assign o_wb      = r_pvld & r_plast;
  assign o_wb_data = w_sum;

endmodule

// File: rtl/fc_core.sv
// Fully-connected Q8.8 engine: feature load, MAC pass, optional bias, buffered result stream.
// Optional FC_RELU_EN macro adds a ReLU clamp on outputs when relu is sampled high at load_w.
module fc_core
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cin,
  input  logic [CNT_W-1:0]  cout,
  input  logic              has_bias,
  input  logic              relu,
  input  logic              load_if,
  input  logic              load_w,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              fc_dout_valid,
  input  logic              fc_dout_ready,
  output logic [DATA_W-1:0] fc_dout_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  fc_state_e r_state, w_state_d;
  logic [CNT_W-1:0] r_cin, w_cin_d, r_cout, w_cout_d;
  logic [IDX_W-1:0] r_i, w_i_d, r_wo, w_wo_d, r_o, w_o_d;
  logic r_bias, w_bias_d, r_err, w_err_d, r_dvalid, w_dvalid_d;
  logic [DATA_W-1:0] r_ddata, w_ddata_d;

  logic        [DATA_W-1:0] r_feat   [MAX_CIN];
  logic signed [ACC_W-1:0]  r_accbuf [MAX_COUT];

  logic                     w_wb;
  logic signed [ACC_W-1:0]  w_wb_data;
  logic signed [DATA_W-1:0] w_opnd;
  logic signed [ACC_W-1:0]  w_bias_add;
  logic [IDX_W-1:0]         w_out_idx;
  logic [DATA_W-1:0]        w_sat, w_out_word;
  logic w_cin_bad, w_cout_bad, w_i_last, w_wo_last, w_o_last, w_unused_in;

  assign w_opnd     = in_data[DATA_W-1:0];
  assign w_bias_add = {{(ACC_W-DATA_W-FRAC_W){w_opnd[DATA_W-1]}}, w_opnd, {FRAC_W{1'b0}}};
  assign w_cin_bad  = (cin == '0) || (cin > CNT_W'(MAX_CIN));
  assign w_cout_bad = (cout == '0) || (cout > CNT_W'(MAX_COUT));
  assign w_i_last   = CNT_W'(r_i) == r_cin - CNT_W'(1);
  assign w_wo_last  = CNT_W'(r_wo) == r_cout - CNT_W'(1);
  assign w_o_last   = CNT_W'(r_o) == r_cout - CNT_W'(1);
  // Once a word is showing, the look-ahead read targets the next entry.
  assign w_out_idx  = r_dvalid ? r_o + IDX_W'(1) : r_o;
  assign w_sat      = sat16(r_accbuf[w_out_idx]);

`ifdef FC_RELU_EN
  logic r_relu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_relu <= 1'b0;
    end else if (r_state == StIdle && load_w && !load_if) begin
      r_relu <= relu;
    end
  end
  assign w_out_word  = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
  assign w_unused_in = ^in_data[31:DATA_W];
`else
  assign w_out_word  = w_sat;
  assign w_unused_in = ^{relu, in_data[31:DATA_W]};
`endif

  fc_mac u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state == StIdle),
    .i_valid   ((r_state == StMac) && in_valid),
    .i_last    (w_i_last),
    .i_feat    (r_feat[r_i]),
    .i_wgt     (w_opnd),
    .o_wb      (w_wb),
    .o_wb_data (w_wb_data)
  );

  always_ff @(posedge clk) begin
    if (r_state == StLoadIf && in_valid) begin
      r_feat[r_i] <= w_opnd;
    end
    if (w_wb) begin
      r_accbuf[r_o] <= w_wb_data;
    end else if (r_state == StBias && in_valid) begin
      r_accbuf[r_o] <= r_accbuf[r_o] + w_bias_add;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cin_d    = r_cin;
    w_cout_d   = r_cout;
    w_bias_d   = r_bias;
    w_err_d    = r_err;
    w_i_d      = r_i;
    w_wo_d     = r_wo;
    w_o_d      = r_o;
    w_dvalid_d = r_dvalid;
    w_ddata_d  = r_ddata;
    if (w_wb) begin
      w_o_d = r_o + IDX_W'(1);
    end
    unique case (r_state)
      StIdle: begin
        if (load_if || load_w) begin
          w_cin_d = cin;
          w_i_d   = '0;
          w_wo_d  = '0;
          w_o_d   = '0;
          w_err_d = w_cin_bad || (!load_if && w_cout_bad);
          if (load_if) begin
            w_state_d = w_err_d ? StDone : StLoadIf;
          end else begin
            w_cout_d  = cout;
            w_bias_d  = has_bias;
            w_state_d = w_err_d ? StDone : StMac;
          end
        end
      end
      StLoadIf: begin
        if (in_valid) begin
          w_i_d = r_i + IDX_W'(1);
          if (w_i_last) begin
            w_i_d     = '0;
            w_state_d = StDone;
          end
        end
      end
      StMac: begin
        if (in_valid) begin
          w_i_d = r_i + IDX_W'(1);
          if (w_i_last) begin
            w_i_d  = '0;
            w_wo_d = r_wo + IDX_W'(1);
            if (w_wo_last) begin
              w_state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        w_o_d     = '0;
        w_state_d = r_bias ? StBias : StOut;
      end
      StBias: begin
        if (in_valid) begin
          w_o_d = r_o + IDX_W'(1);
          if (w_o_last) begin
            w_o_d     = '0;
            w_state_d = StOut;
          end
        end
      end
      StOut: begin
        if (!r_dvalid) begin
          w_dvalid_d = 1'b1;
          w_ddata_d  = w_out_word;
        end else if (fc_dout_ready) begin
          if (w_o_last) begin
            w_dvalid_d = 1'b0;
            w_state_d  = StDone;
          end else begin
            w_o_d     = r_o + IDX_W'(1);
            w_ddata_d = w_out_word;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cin    <= '0;
      r_cout   <= '0;
      r_bias   <= 1'b0;
      r_err    <= 1'b0;
      r_i      <= '0;
      r_wo     <= '0;
      r_o      <= '0;
      r_dvalid <= 1'b0;
      r_ddata  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cin    <= w_cin_d;
      r_cout   <= w_cout_d;
      r_bias   <= w_bias_d;
      r_err    <= w_err_d;
      r_i      <= w_i_d;
      r_wo     <= w_wo_d;
      r_o      <= w_o_d;
      r_dvalid <= w_dvalid_d;
      r_ddata  <= w_ddata_d;
    end
  end

  assign fc_dout_valid = r_dvalid;
  assign fc_dout_data  = r_ddata;
  assign busy          = r_state != StIdle;
  assign done          = r_state == StDone;
  assign err           = r_err;

endmodule

// File: tb/tb_fc_core.sv
// Self-checking bench for fc_core: vector table of layer runs, output scoreboard, corner sequences.
module tb_fc_core;

  logic        clk, rst_n;
  logic [11:0] cin, cout;
  logic        has_bias, relu, load_if, load_w, in_valid;
  logic [31:0] in_data;
  logic        fc_dout_valid, fc_dout_ready;
  logic [15:0] fc_dout_data;
  logic        busy, done, err;

  fc_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cin           (cin),
    .cout          (cout),
    .has_bias      (has_bias),
    .relu          (relu),
    .load_if       (load_if),
    .load_w        (load_w),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .fc_dout_valid (fc_dout_valid),
    .fc_dout_ready (fc_dout_ready),
    .fc_dout_data  (fc_dout_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  typedef struct packed {
    logic [11:0]      ci;
    logic [11:0]      co;
    logic             hb;
    logic             ld;
    logic [3:0][15:0] ft;
    logic [7:0][15:0] wt;
    logic [1:0][15:0] bs;
    logic [1:0][15:0] ex;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_cnt  = 0;
  logic [15:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && fc_dout_valid && fc_dout_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected output: got %h with empty scoreboard", fc_dout_data);
      end else begin
        check("dout", 32'(fc_dout_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fc_dout_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_features(input int n, input logic [3:0][15:0] ft, output bit ok);
    cin = 12'(n);
    load_if = 1'b1;
    tick();
    load_if = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = {16'h5A5A, ft[k]};
      tick();
    end
    in_valid = 1'b0;
    wait_done(ok);
  endtask

  // Drives load_w, all weights, a stray word in the FLUSH cycle, then bias words.
  task automatic send_layer(input vec_t v, input bit push);
    cin = v.ci;
    cout = v.co;
    has_bias = v.hb;
    load_w = 1'b1;
    tick();
    load_w = 1'b0;
    if (push) for (int o = 0; o < int'(v.co); o++) sb.push_back(v.ex[o]);
    for (int k = 0; k < int'(v.ci) * int'(v.co); k++) begin
      in_valid = 1'b1;
      in_data  = {16'hA5A5, v.wt[k]};
      tick();
    end
    in_data = 32'h0000_7FFF;
    tick();
    if (v.hb) begin
      for (int o = 0; o < int'(v.co); o++) begin
        in_data = {16'hC3C3, v.bs[o]};
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_layer(input vec_t v, input string tag);
    bit ok;
    int hs0;
    if (v.ld) begin
      load_features(int'(v.ci), v.ft, ok);
      check({tag, " if_done"}, 32'(ok), 32'd1);
    end
    hs0 = hs_cnt;
    send_layer(v, 1'b1);
    wait_done(ok);
    check({tag, " done"}, 32'(ok), 32'd1);
    check({tag, " handshakes"}, 32'(hs_cnt - hs0), 32'(v.co));
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  vec_t vecs[6];
  vec_t vb, vr;

  initial begin
    bit ok;
    int hs0;
    logic [1:0][15:0] rex;

    vecs[0] = '{ci: 12'd2, co: 12'd2, hb: 1'b0, ld: 1'b1,
                ft: {16'h0, 16'h0, 16'h0200, 16'h0100},
                wt: {16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'h0080, 16'h0100, 16'h0100},
                bs: {16'h0, 16'h0}, ex: {16'hFE80, 16'h0300}};
    // Reuses the features left by the previous vector.
    vecs[1] = '{ci: 12'd2, co: 12'd2, hb: 1'b1, ld: 1'b0,
                ft: {16'h0, 16'h0, 16'h0200, 16'h0100},
                wt: {16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'h0080, 16'h0100, 16'h0100},
                bs: {16'h0100, 16'h0080}, ex: {16'hFF80, 16'h0380}};
    vecs[2] = '{ci: 12'd4, co: 12'd1, hb: 1'b0, ld: 1'b1,
                ft: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                wt: {16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                bs: {16'h0, 16'h0}, ex: {16'h0, 16'h7FFF}};
    vecs[3] = '{ci: 12'd4, co: 12'd1, hb: 1'b0, ld: 1'b1,
                ft: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                wt: {16'h0, 16'h0, 16'h0, 16'h0, 16'h8001, 16'h8001, 16'h8001, 16'h8001},
                bs: {16'h0, 16'h0}, ex: {16'h0, 16'h8000}};
    vecs[4] = '{ci: 12'd1, co: 12'd2, hb: 1'b0, ld: 1'b1,
                ft: {16'h0, 16'h0, 16'h0, 16'h0180},
                wt: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFF80, 16'h0200},
                bs: {16'h0, 16'h0}, ex: {16'hFF40, 16'h0300}};
    vecs[5] = '{ci: 12'd1, co: 12'd1, hb: 1'b0, ld: 1'b1,
                ft: {16'h0, 16'h0, 16'h0, 16'h0001},
                wt: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF},
                bs: {16'h0, 16'h0}, ex: {16'h0, 16'hFFFF}};
    vb = vecs[0];
    vb.ld = 1'b0;

    rst_n = 1'b0;
    cin = '0; cout = '0; has_bias = 1'b0; relu = 1'b0;
    load_if = 1'b0; load_w = 1'b0; in_valid = 1'b0; in_data = '0;
    fc_dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", 32'(fc_dout_valid), 32'd0);
    check("rst data", 32'(fc_dout_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 6; n++) run_layer(vecs[n], $sformatf("vec%0d", n));

    // Backpressure on word 0.
    load_features(2, vb.ft, ok);
    hs0 = hs_cnt;
    fc_dout_ready = 1'b0;
    send_layer(vb, 1'b1);
    wait_valid(ok);
    check("bp valid rose", 32'(ok), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("bp hold valid", 32'(fc_dout_valid), 32'd1);
      check("bp hold data", 32'(fc_dout_data), 32'h0300);
    end
    tick();
    fc_dout_ready = 1'b1;
    wait_done(ok);
    check("bp done", 32'(ok), 32'd1);
    check("bp handshakes", 32'(hs_cnt - hs0), 32'd2);
    check("bp sb_empty", 32'(sb.size()), 32'd0);

    // Illegal sizes set err; a good start clears it.
    hs0 = hs_cnt;
    vr = vb;
    vr.co = 12'd0;
    cin = 12'd2; cout = 12'd0; load_w = 1'b1;
    tick();
    load_w = 1'b0;
    wait_done(ok);
    check("cout0 done", 32'(ok), 32'd1);
    check("cout0 err", 32'(err), 32'd1);
    check("cout0 no output", 32'(hs_cnt - hs0), 32'd0);
    cin = 12'd0; load_if = 1'b1;
    tick();
    load_if = 1'b0;
    wait_done(ok);
    check("cin0 err", 32'(err), 32'd1);
    load_features(2, vb.ft, ok);
    check("good start clears err", 32'(err), 32'd0);
    cin = 12'd1025; cout = 12'd1; load_w = 1'b1;
    tick();
    load_w = 1'b0;
    wait_done(ok);
    check("cin1025 err", 32'(err), 32'd1);

    // load_if wins over load_w: done after only cin words.
    cin = 12'd2; cout = 12'd2; load_if = 1'b1; load_w = 1'b1;
    tick();
    load_if = 1'b0; load_w = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = {16'h0, vb.ft[k]};
      tick();
    end
    in_valid = 1'b0;
    wait_done(ok);
    check("prio load_if done", 32'(ok), 32'd1);
    check("prio err", 32'(err), 32'd0);
    check("prio no output", 32'(hs_cnt - hs0), 32'd0);

    // Reset mid-MAC.
    cin = 12'd2; cout = 12'd2; has_bias = 1'b0; load_w = 1'b1;
    tick();
    load_w = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = {16'h0, vb.wt[k]};
      tick();
    end
    check("mid-mac busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst mid-mac busy", 32'(busy), 32'd0);
    check("rst mid-mac valid", 32'(fc_dout_valid), 32'd0);
    check("rst mid-mac done", 32'(done), 32'd0);
    do_reset();

    // Reset while a word is waiting on the output.
    load_features(2, vb.ft, ok);
    fc_dout_ready = 1'b0;
    send_layer(vb, 1'b0);
    wait_valid(ok);
    check("out valid before rst", 32'(ok), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid-out valid", 32'(fc_dout_valid), 32'd0);
    check("rst mid-out busy", 32'(busy), 32'd0);
    fc_dout_ready = 1'b1;
    do_reset();

    // ReLU request on the basic layer.
`ifdef FC_RELU_EN
    rex = {16'h0000, 16'h0300};
`else
    rex = {16'hFE80, 16'h0300};
`endif
    vr = vecs[0];
    vr.ex = rex;
    relu = 1'b1;
    run_layer(vr, "relu");
    relu = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
